ptp_ctrl_mp: RTL and testbench

- Parametrised successor of the single-port PTP handshake controller. Supports N_PORTS receive channels in master role and a timeout/retry-protected slave exchange.
- Master: collects DELAY_REQ arrivals per port in a pending bitmap, then issues DELAY_RESP requests to tx_proc round-robin, one outstanding at a time.
- Slave: runs SYNC -> DELAY_REQ -> DELAY_RESP on channel 0, with per-state timeout and bounded DELAY_REQ retry.
- Sits between rx_proc/tx_proc and cyc_sync.

---
 rtl/ptp_pkg.sv | 24 ++
 rtl/ptp_rr_arb.sv | 28 ++
 rtl/ptp_ctrl_mp.sv | 248 ++++++++++++++++++++++++
 tb/tb_ptp_ctrl_mp.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ptp_pkg.sv
// Shared constants for the multi-port PTP handshake controller:
// message types, error codes and the controller state encoding.
package ptp_pkg;

    localparam logic [3:0] PTP_SYNC  = 4'd1;
    localparam logic [3:0] PTP_DREQ  = 4'd3;
    localparam logic [3:0] PTP_DRESP = 4'd4;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_UNEXP   = 3'd1;
    localparam logic [2:0] ERR_TIMEOUT = 3'd2;
    localparam logic [2:0] ERR_RETRY   = 3'd3;
    localparam logic [2:0] ERR_TXTYPE  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_M_ARB       = 3'd1,
        ST_M_WAIT_TX   = 3'd2,
        ST_S_WAIT_SYNC = 3'd3,
        ST_S_WAIT_TX   = 3'd4,
        ST_S_WAIT_RESP = 3'd5
    } ptp_state_e;

endpackage

// File: rtl/ptp_rr_arb.sv
// Round-robin pick: first set request at or after the pointer, wrapping at
// N_PORTS. Purely combinational; the caller owns the pointer register.
module ptp_rr_arb #(
    parameter int N_PORTS = 4,
    parameter int PW      = 2
) (
    input  logic [N_PORTS-1:0] i_req,
    input  logic [PW-1:0]      i_ptr,
    output logic [PW-1:0]      o_idx,
    output logic               o_valid
);

    // Scan offsets from far to near so the nearest hit is the last write.
    always_comb begin
        int p;
        o_idx   = '0;
        o_valid = 1'b0;
        p       = 0;
        for (int k = N_PORTS - 1; k >= 0; k--) begin
            p = (int'(i_ptr) + k) % N_PORTS;
            if (i_req[p]) begin
                o_idx   = PW'(p);
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ptp_ctrl_mp.sv
// Multi-port PTP handshake controller: round-robin DELAY_RESP master and
// timeout/retry-protected slave. Define PTP_CTRL_STATS_EN for the pulse/error counters.
module ptp_ctrl_mp
    import ptp_pkg::*;
#(
    parameter int              N_PORTS     = 4,
    parameter int              PW          = 2,
    parameter int              TO_W        = 20,
    parameter logic [TO_W-1:0] TIMEOUT_CYC = 20'd500000,
    parameter int              MAX_RETRY   = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_PORTS-1:0]   recv_type_valid,
    input  logic [4*N_PORTS-1:0] recv_type,
    input  logic                 send_type_valid,
    input  logic [3:0]           send_type,
    input  logic                 sync_start,
    input  logic [1:0]           device_role,
    output logic                 send_dreq_pkt,
    output logic                 send_dresq_pkt,
    output logic [PW-1:0]        send_dresq_port,
    output logic                 m_or_s,
    output logic                 status_ok,
    output logic                 error,
    output logic [2:0]           err_code,
    output logic [31:0]          dreq_cnt,
    output logic [31:0]          dresp_cnt
);

    localparam int              RW      = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [TO_W-1:0] TO_LAST = TIMEOUT_CYC - TO_W'(1);

    ptp_state_e          r_state;
    logic [N_PORTS-1:0]  r_pending;
    logic [PW-1:0]       r_rr_ptr;
    logic [TO_W-1:0]     r_timer;
    logic [RW-1:0]       r_retry;
    logic                r_send_dreq;
    logic                r_send_dresq;
    logic [PW-1:0]       r_send_dresq_port;
    logic                r_status_ok;
    logic                r_error;
    logic [2:0]          r_err_code;

    logic [N_PORTS-1:0]  w_dreq_set;
    logic [N_PORTS-1:0]  w_clr;
    logic [PW-1:0]       w_gnt_idx;
    logic                w_gnt_valid;
    logic                w_in_master;
    logic                w_in_wait;
    logic                w_timeout;
    logic                w_rx0_valid;
    logic [3:0]          w_rx0_type;
    logic                w_unused_role;

    assign w_unused_role = device_role[1];

    assign w_in_master = (r_state == ST_M_ARB) || (r_state == ST_M_WAIT_TX);
    assign w_in_wait   = (r_state == ST_M_WAIT_TX) || (r_state == ST_S_WAIT_SYNC) ||
                         (r_state == ST_S_WAIT_TX) || (r_state == ST_S_WAIT_RESP);
    assign w_timeout   = w_in_wait && (r_timer == TO_LAST);
    assign w_rx0_valid = recv_type_valid[0];
    assign w_rx0_type  = recv_type[3:0];

    generate
        for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_port
            assign w_dreq_set[gi] = recv_type_valid[gi] && (recv_type[4*gi +: 4] == PTP_DREQ);
            assign w_clr[gi]      = (r_state == ST_M_ARB) && w_gnt_valid && (w_gnt_idx == PW'(gi));
        end
    endgenerate

    ptp_rr_arb #(
        .N_PORTS (N_PORTS),
        .PW      (PW)
    ) u_arb (
        .i_req   (r_pending),
        .i_ptr   (r_rr_ptr),
        .o_idx   (w_gnt_idx),
        .o_valid (w_gnt_valid)
    );

    // Every state change also zeroes the timer; that write overrides the count-up.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state           <= ST_IDLE;
            r_pending         <= '0;
            r_rr_ptr          <= '0;
            r_timer           <= '0;
            r_retry           <= '0;
            r_send_dreq       <= 1'b0;
            r_send_dresq      <= 1'b0;
            r_send_dresq_port <= '0;
            r_status_ok       <= 1'b0;
            r_error           <= 1'b0;
            r_err_code        <= ERR_NONE;
        end else begin
            r_send_dreq       <= 1'b0;
            r_send_dresq      <= 1'b0;
            r_send_dresq_port <= '0;
            r_status_ok       <= 1'b0;
            r_error           <= 1'b0;
            if ((r_state != ST_IDLE) && !sync_start) begin
                r_state   <= ST_IDLE;
                r_pending <= '0;
                r_timer   <= '0;
                r_retry   <= '0;
            end else begin
                // Set after clear: a new request on the granted port survives.
                if (w_in_master)
                    r_pending <= (r_pending & ~w_clr) | w_dreq_set;
                if (w_in_wait && (r_timer != TO_LAST))
                    r_timer <= r_timer + TO_W'(1);
                case (r_state)
                    ST_IDLE: begin
                        if (sync_start) begin
                            r_state <= device_role[0] ? ST_M_ARB : ST_S_WAIT_SYNC;
                            r_timer <= '0;
                            r_retry <= '0;
                        end
                    end
                    ST_M_ARB: begin
                        if (w_gnt_valid) begin
                            r_send_dresq      <= 1'b1;
                            r_send_dresq_port <= w_gnt_idx;
                            r_rr_ptr          <= (w_gnt_idx == PW'(N_PORTS - 1)) ? '0 : w_gnt_idx + PW'(1);
                            r_state           <= ST_M_WAIT_TX;
                            r_timer           <= '0;
                        end
                    end
                    ST_M_WAIT_TX: begin
                        if (send_type_valid) begin
                            if (send_type != PTP_DRESP) begin
                                r_error    <= 1'b1;
                                r_err_code <= ERR_TXTYPE;
                            end
                            r_state <= ST_M_ARB;
                            r_timer <= '0;
                        end else if (w_timeout) begin
                            r_error    <= 1'b1;
                            r_err_code <= ERR_TIMEOUT;
                            r_state    <= ST_M_ARB;
                            r_timer    <= '0;
                        end
                    end
                    ST_S_WAIT_SYNC: begin
                        if (w_rx0_valid && (w_rx0_type == PTP_SYNC)) begin
                            r_send_dreq <= 1'b1;
                            r_state     <= ST_S_WAIT_TX;
                            r_timer     <= '0;
                        end else if (w_timeout) begin
                            r_error    <= 1'b1;
                            r_err_code <= ERR_TIMEOUT;
                            r_state    <= ST_IDLE;
                            r_timer    <= '0;
                        end
                    end
                    ST_S_WAIT_TX: begin
                        if (send_type_valid) begin
                            if (send_type == PTP_DREQ) begin
                                r_state <= ST_S_WAIT_RESP;
                            end else begin
                                r_error    <= 1'b1;
                                r_err_code <= ERR_TXTYPE;
                                r_state    <= ST_IDLE;
                            end
                            r_timer <= '0;
                        end else if (w_timeout) begin
                            r_error    <= 1'b1;
                            r_err_code <= ERR_TIMEOUT;
                            r_state    <= ST_IDLE;
                            r_timer    <= '0;
                        end
                    end
                    ST_S_WAIT_RESP: begin
                        if (w_rx0_valid) begin
                            if (w_rx0_type == PTP_DRESP) begin
                                r_status_ok <= 1'b1;
                                r_retry     <= '0;
                                r_state     <= ST_S_WAIT_SYNC;
                            end else if (w_rx0_type == PTP_SYNC) begin
                                r_send_dreq <= 1'b1;
                                r_state     <= ST_S_WAIT_TX;
                            end else begin
                                r_error    <= 1'b1;
                                r_err_code <= ERR_UNEXP;
                                r_state    <= ST_IDLE;
                            end
                            r_timer <= '0;
                        end else if (w_timeout) begin
                            if (r_retry < RW'(MAX_RETRY)) begin
                                r_retry     <= r_retry + RW'(1);
                                r_send_dreq <= 1'b1;
                                r_state     <= ST_S_WAIT_TX;
                            end else begin
                                r_error    <= 1'b1;
                                r_err_code <= ERR_RETRY;
                                r_state    <= ST_IDLE;
                            end
                            r_timer <= '0;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_timer <= '0;
                    end
                endcase
            end
        end
    end

    assign send_dreq_pkt   = r_send_dreq;
    assign send_dresq_pkt  = r_send_dresq;
    assign send_dresq_port = r_send_dresq_port;
    assign status_ok       = r_status_ok;
    assign error           = r_error;
    assign err_code        = r_err_code;
    assign m_or_s          = device_role[0];

`ifdef PTP_CTRL_STATS_EN
    logic [31:0] r_dreq_cnt;
    logic [31:0] r_dresp_cnt;
    logic [15:0] r_err_cnt;

    // Counters follow the registered pulses, so they lag the pulse by one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dreq_cnt  <= '0;
            r_dresp_cnt <= '0;
            r_err_cnt   <= '0;
        end else begin
            if (r_send_dreq)
                r_dreq_cnt <= r_dreq_cnt + 32'd1;
            if (r_send_dresq)
                r_dresp_cnt <= r_dresp_cnt + 32'd1;
            if (r_error && (r_err_cnt != 16'hFFFF))
                r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign dreq_cnt  = r_dreq_cnt;
    assign dresp_cnt = r_dresp_cnt;
`else
    assign dreq_cnt  = '0;
    assign dresp_cnt = '0;
`endif

endmodule

// File: tb/tb_ptp_ctrl_mp.sv
// Scoreboard bench for ptp_ctrl_mp: expected pulses are queued as stimulus is
// driven and popped as the DUT emits send_dresq/send_dreq/status_ok/error.
module tb_ptp_ctrl_mp;
    import ptp_pkg::*;

    localparam int NP = 4;
    localparam int PW = 2;
    localparam int K_DRESQ = 0;
    localparam int K_DREQ  = 1;
    localparam int K_OK    = 2;
    localparam int K_ERR   = 3;
`ifdef PTP_CTRL_STATS_EN
    localparam logic [31:0] STATS_MASK = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] STATS_MASK = 32'h0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NP-1:0]     recv_type_valid = '0;
    logic [4*NP-1:0]   recv_type = '0;
    logic              send_type_valid = 1'b0;
    logic [3:0]        send_type = '0;
    logic              sync_start = 1'b0;
    logic [1:0]        device_role = '0;
    logic              send_dreq_pkt;
    logic              send_dresq_pkt;
    logic [PW-1:0]     send_dresq_port;
    logic              m_or_s;
    logic              status_ok;
    logic              error;
    logic [2:0]        err_code;
    logic [31:0]       dreq_cnt;
    logic [31:0]       dresp_cnt;

    always #5 clk = ~clk;

    ptp_ctrl_mp #(
        .N_PORTS     (NP),
        .PW          (PW),
        .TO_W        (20),
        .TIMEOUT_CYC (20'd16),
        .MAX_RETRY   (3)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .recv_type_valid (recv_type_valid),
        .recv_type       (recv_type),
        .send_type_valid (send_type_valid),
        .send_type       (send_type),
        .sync_start      (sync_start),
        .device_role     (device_role),
        .send_dreq_pkt   (send_dreq_pkt),
        .send_dresq_pkt  (send_dresq_pkt),
        .send_dresq_port (send_dresq_port),
        .m_or_s          (m_or_s),
        .status_ok       (status_ok),
        .error           (error),
        .err_code        (err_code),
        .dreq_cnt        (dreq_cnt),
        .dresp_cnt       (dresp_cnt)
    );

    typedef struct {
        int kind;
        int val;
    } ev_t;

    ev_t        sb[$];
    int         n_checks  = 0;
    int         n_pass    = 0;
    int         exp_dreq  = 0;
    int         exp_dresp = 0;
    int         dreq_seen = 0;
    logic [2:0] err_state = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else
            n_pass++;
    endtask

    function automatic logic [31:0] exp_cnt(input int n);
        return 32'(n) & STATS_MASK;
    endfunction

    task automatic push(input int kind, input int val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        sb.push_back(e);
        if (kind == K_DREQ)  exp_dreq++;
        if (kind == K_DRESQ) exp_dresp++;
    endtask

    task automatic sb_pop(input int kind, input int val);
        ev_t e;
        check($sformatf("sb_expected_kind%0d", kind), 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("sb_kind", 32'(kind), 32'(e.kind));
            check($sformatf("sb_val_kind%0d", kind), 32'(val), 32'(e.val));
            $display("[%0t] event kind=%0d val=%0d (exp kind=%0d val=%0d)", $time, kind, val, e.kind, e.val);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (send_dresq_pkt) sb_pop(K_DRESQ, int'(send_dresq_port));
            if (send_dreq_pkt) begin
                dreq_seen++;
                sb_pop(K_DREQ, 0);
            end
            if (status_ok) sb_pop(K_OK, 0);
            if (error) begin
                err_state = dut.r_state;
                sb_pop(K_ERR, int'(err_code));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rx_pulse(input logic [NP-1:0] v, input logic [4*NP-1:0] t);
        recv_type_valid = v;
        recv_type       = t;
        tick(1);
        recv_type_valid = '0;
        recv_type       = '0;
    endtask

    task automatic tx_pulse(input logic [3:0] t);
        send_type_valid = 1'b1;
        send_type       = t;
        tick(1);
        send_type_valid = 1'b0;
        send_type       = '0;
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((sb.size() != 0) && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(sb.size()), 32'd0);
    endtask

    task automatic do_reset();
        reset      = 1'b0;
        sync_start = 1'b0;
        recv_type_valid = '0;
        send_type_valid = 1'b0;
        sb.delete();
        exp_dreq  = 0;
        exp_dresp = 0;
        tick(3);
        reset = 1'b1;
        tick(1);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_dreq"},  32'(send_dreq_pkt),   32'd0);
        check({tag, "_dresq"}, 32'(send_dresq_pkt),  32'd0);
        check({tag, "_port"},  32'(send_dresq_port), 32'd0);
        check({tag, "_ok"},    32'(status_ok),       32'd0);
        check({tag, "_err"},   32'(error),           32'd0);
        check({tag, "_code"},  32'(err_code),        32'd0);
        check({tag, "_state"}, 32'(dut.r_state),     32'(ST_IDLE));
    endtask

    initial begin
        int base;
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int base;
        // Reset state
        #2;
        check_quiet("reset");
        check("reset_dreq_cnt",  dreq_cnt,  32'd0);
        check("reset_dresp_cnt", dresp_cnt, 32'd0);
        check("reset_m_or_s",    32'(m_or_s), 32'd0);
        device_role = 2'b01;
        #1;
        check("m_or_s_follow", 32'(m_or_s), 32'd1);
        do_reset();

        // Master: simultaneous requests on ports 1 and 3
        device_role = 2'b01;
        sync_start  = 1'b1;
        tick(2);
        push(K_DRESQ, 1);
        rx_pulse(4'b1010, 16'h3030);
        drain("m_grant1", 50);
        push(K_DRESQ, 3);
        tx_pulse(4'd4);
        drain("m_grant3", 50);
        tx_pulse(4'd4);
        tick(2);
        check("m_dresp_cnt2", dresp_cnt, exp_cnt(exp_dresp));
        check("m_dreq_cnt0",  dreq_cnt,  exp_cnt(0));

        // Master: SYNC on port 0 ignored, tx type mismatch, then tx timeout
        push(K_DRESQ, 2);
        rx_pulse(4'b0101, 16'h0301);
        drain("m_grant2", 50);
        rx_pulse(4'b0011, 16'h0033);
        push(K_ERR, int'(ERR_TXTYPE));
        push(K_DRESQ, 0);
        push(K_ERR, int'(ERR_TIMEOUT));
        push(K_DRESQ, 1);
        tx_pulse(4'd1);
        drain("m_err_seq", 100);
        check("m_err_code_held", 32'(err_code), 32'(ERR_TIMEOUT));
        tx_pulse(4'd4);
        tick(2);
        check("m_dresp_cnt5", dresp_cnt, exp_cnt(exp_dresp));

        // Slave: full exchange
        do_reset();
        device_role = 2'b00;
        sync_start  = 1'b1;
        tick(2);
        push(K_DREQ, 0);
        rx_pulse(4'b0001, 16'h0001);
        drain("s_dreq", 50);
        tx_pulse(4'd3);
        push(K_OK, 0);
        rx_pulse(4'b0001, 16'h0004);
        drain("s_ok", 50);
        check("s_state_wait_sync", 32'(dut.r_state), 32'(ST_S_WAIT_SYNC));
        tick(2);
        check("s_dreq_cnt1", dreq_cnt, exp_cnt(exp_dreq));

        // Slave: DELAY_RESP never arrives, retries exhaust
        base = dreq_seen;
        push(K_DREQ, 0);
        rx_pulse(4'b0001, 16'h0001);
        for (int i = 0; i < 4; i++) begin
            drain($sformatf("s_retry%0d", i), 100);
            if (i < 3) push(K_DREQ, 0);
            else       push(K_ERR, int'(ERR_RETRY));
            tx_pulse(4'd3);
        end
        drain("s_retry_err", 100);
        check("s_retry_state_idle", 32'(err_state), 32'(ST_IDLE));
        check("s_retry_dreq_pulses", 32'(dreq_seen - base), 32'd4);
        check("s_retry_err_code", 32'(err_code), 32'(ERR_RETRY));
        tick(2);
        check("s_dreq_cnt5", dreq_cnt, exp_cnt(exp_dreq));

        // sync_start falls in S_WAIT_RESP
        do_reset();
        device_role = 2'b00;
        sync_start  = 1'b1;
        tick(2);
        push(K_DREQ, 0);
        rx_pulse(4'b0001, 16'h0001);
        drain("stop_dreq", 50);
        tx_pulse(4'd3);
        tick(1);
        check("stop_in_wait_resp", 32'(dut.r_state), 32'(ST_S_WAIT_RESP));
        sync_start = 1'b0;
        tick(2);
        check_quiet("stop");
        check("stop_dreq_cnt", dreq_cnt, exp_cnt(exp_dreq));

        // Reset asserted in M_WAIT_TX
        device_role = 2'b01;
        sync_start  = 1'b1;
        tick(2);
        push(K_DRESQ, 2);
        rx_pulse(4'b0100, 16'h0300);
        drain("rst_grant", 50);
        tick(1);
        check("rst_in_wait_tx", 32'(dut.r_state), 32'(ST_M_WAIT_TX));
        reset = 1'b0;
        #1;
        check_quiet("rst_mid");
        check("rst_mid_dreq_cnt",  dreq_cnt,  32'd0);
        check("rst_mid_dresp_cnt", dresp_cnt, 32'd0);
        sync_start = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(2);
        check("rst_after_state", 32'(dut.r_state), 32'(ST_IDLE));
        check("sb_final_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
